// File: rtl/sdram_arb_pkg.sv
// Shared state/grant encodings and default widths for the SDRAM arbiter.
package sdram_arb_pkg;

  localparam int DEF_ADDR_WIDTH    = 25;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_CPU_BURST_MAX = 4;
  localparam int DEF_REF_INTERVAL  = 390;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2,
    REF     = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2,
    GNT_REF  = 2'd3
  } grant_t;

endpackage

// File: rtl/sdram_arbiter_refresh_timer.sv
// Periodic refresh scheduler: free-running interval counter plus a single,
// non-stacking pending flag. Instantiated only when SDRAM_ARB_REFRESH_EN is set.
module refresh_timer #(
  parameter int REF_INTERVAL = 390
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic ref_pending
);

  localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_INTERVAL - 1);

  logic [CNT_W-1:0] cnt;

  // A wrap coinciding with the clear re-arms the flag so that interval is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      ref_pending <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt         <= '0;
      ref_pending <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      if (clr) ref_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the single SDRAM adapter port between CPU, DMA and (with
// SDRAM_ARB_REFRESH_EN defined) an internal periodic refresh scheduler.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int CPU_BURST_MAX = DEF_CPU_BURST_MAX
`ifdef SDRAM_ARB_REFRESH_EN
  ,
  parameter int REF_INTERVAL  = DEF_REF_INTERVAL
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_cpu_cs,
  input  logic                  i_cpu_rwb,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_data,
  output logic [DATA_WIDTH-1:0] o_cpu_data,
  output logic                  o_cpu_wait,
  input  logic                  i_dma_req,
  input  logic                  i_dma_we,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [DATA_WIDTH-1:0] i_dma_wdata,
  output logic                  o_dma_ack,
  output logic [DATA_WIDTH-1:0] o_dma_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_ref,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int STREAK_W = $clog2(CPU_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CPU_BURST_MAX);

  arb_state_t            state;
  grant_t                grant;
  logic [STREAK_W-1:0]   cpu_streak;
  logic                  cpu_done_q;
  logic                  cpu_rwb_q;
  logic [ADDR_WIDTH-1:0] cpu_addr_q;
  logic                  cpu_done;
  logic                  ref_pending;

  // Completion only holds while the CPU keeps presenting the request it was for,
  // so a new address re-arbitrates in the very cycle it appears.
  assign cpu_done   = cpu_done_q && (i_cpu_addr == cpu_addr_q) && (i_cpu_rwb == cpu_rwb_q);
  assign o_cpu_wait = i_cpu_cs & ~cpu_done;

`ifdef SDRAM_ARB_REFRESH_EN
  logic ref_clr;
  assign ref_clr = (state == REF) && i_mem_ack;

  refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_refresh_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (ref_clr),
    .ref_pending (ref_pending)
  );
`else
  assign ref_pending = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (ref_pending)                                  grant = GNT_REF;
    else if (i_dma_req && (cpu_streak >= STREAK_MAX)) grant = GNT_DMA;
    else if (i_cpu_cs && !cpu_done)                   grant = GNT_CPU;
    else if (i_dma_req)                               grant = GNT_DMA;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      o_mem_req   <= 1'b0;
      o_mem_ref   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cpu_data  <= '0;
      o_dma_ack   <= 1'b0;
      o_dma_rdata <= '0;
    end else begin
      o_dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          case (grant)
            GNT_REF: begin
              o_mem_ref <= 1'b1;
              state     <= REF;
            end
            GNT_CPU: begin
              o_mem_req   <= 1'b1;
              o_mem_we    <= ~i_cpu_rwb;
              o_mem_addr  <= i_cpu_addr;
              o_mem_wdata <= i_cpu_data;
              state       <= CPU_ACC;
            end
            GNT_DMA: begin
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_dma_we;
              o_mem_addr  <= i_dma_addr;
              o_mem_wdata <= i_dma_wdata;
              state       <= DMA_ACC;
            end
            default: ;
          endcase
        end
        CPU_ACC: if (i_mem_ack) begin
          if (cpu_rwb_q) o_cpu_data <= i_mem_rdata;
          o_mem_req <= 1'b0;
          state     <= IDLE;
        end
        DMA_ACC: if (i_mem_ack) begin
          o_dma_ack   <= 1'b1;
          o_dma_rdata <= i_mem_rdata;
          o_mem_req   <= 1'b0;
          state       <= IDLE;
        end
        REF: if (i_mem_ack) begin
          o_mem_ref <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_done_q <= 1'b0;
      cpu_rwb_q  <= 1'b0;
      cpu_addr_q <= '0;
    end else begin
      if (state == IDLE && grant == GNT_CPU) begin
        cpu_addr_q <= i_cpu_addr;
        cpu_rwb_q  <= i_cpu_rwb;
      end
      if (state == CPU_ACC && i_mem_ack)                            cpu_done_q <= 1'b1;
      else if (!i_cpu_cs || i_cpu_addr != cpu_addr_q || i_cpu_rwb != cpu_rwb_q) cpu_done_q <= 1'b0;
    end
  end

  // Fairness counter: caps back-to-back CPU grants while DMA is waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                           cpu_streak <= '0;
    else if (!i_dma_req)                                    cpu_streak <= '0;
    else if (state == IDLE && grant == GNT_DMA)             cpu_streak <= '0;
    else if (state == IDLE && grant == GNT_CPU && cpu_streak < STREAK_MAX)
      cpu_streak <= cpu_streak + 1'b1;
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: behavioural SDRAM adapter, grant
// monitor and per-requester shadow memories; honours SDRAM_ARB_REFRESH_EN.
module tb_sdram_arbiter;

  localparam int AW = 25;
  localparam int DW = 8;
  localparam int BURST = 4;
  localparam int BUDGET = 200;
  localparam logic [AW-1:0] DMA_BASE = 25'h1000000;
`ifdef SDRAM_ARB_REFRESH_EN
  localparam int REF_IV = 16;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_cpu_cs = 1'b0, i_cpu_rwb = 1'b1;
  logic [AW-1:0] i_cpu_addr = '0;
  logic [DW-1:0] i_cpu_data = '0;
  logic [DW-1:0] o_cpu_data;
  logic          o_cpu_wait;
  logic          i_dma_req = 1'b0, i_dma_we = 1'b0;
  logic [AW-1:0] i_dma_addr = '0;
  logic [DW-1:0] i_dma_wdata = '0;
  logic          o_dma_ack;
  logic [DW-1:0] o_dma_rdata;
  logic          o_mem_req, o_mem_we, o_mem_ref;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ack = 1'b0;
  logic [DW-1:0] i_mem_rdata = '0;

  sdram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_BURST_MAX(BURST)
`ifdef SDRAM_ARB_REFRESH_EN
    , .REF_INTERVAL(REF_IV)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cpu_cs(i_cpu_cs), .i_cpu_rwb(i_cpu_rwb), .i_cpu_addr(i_cpu_addr),
    .i_cpu_data(i_cpu_data), .o_cpu_data(o_cpu_data), .o_cpu_wait(o_cpu_wait),
    .i_dma_req(i_dma_req), .i_dma_we(i_dma_we), .i_dma_addr(i_dma_addr),
    .i_dma_wdata(i_dma_wdata), .o_dma_ack(o_dma_ack), .o_dma_rdata(o_dma_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_ref(o_mem_ref),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rel_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural SDRAM adapter ----------------
  logic [DW-1:0] sdram [logic [AW-1:0]];
  bit            adp_en = 1'b1;
  int            adp_fixed = 0;
  bit            adp_busy = 1'b0;
  int            adp_cnt = 0;
  logic [AW-1:0] h_addr;
  logic          h_we, h_ref;
  logic [DW-1:0] h_wdata;

  function automatic logic [DW-1:0] sdram_rd(input logic [AW-1:0] a);
    return sdram.exists(a) ? sdram[a] : '0;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (i_mem_ack) begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = DW'($urandom);
        adp_busy    = 1'b0;
      end else if (adp_en && reset_n && (o_mem_req || o_mem_ref)) begin
        if (!adp_busy) begin
          adp_busy = 1'b1;
          adp_cnt  = (adp_fixed > 0) ? adp_fixed : int'($urandom_range(2, 4));
          h_addr = o_mem_addr; h_we = o_mem_we; h_wdata = o_mem_wdata; h_ref = o_mem_ref;
        end
        adp_cnt--;
        if (adp_cnt == 0) begin
          checks++;
          if ({o_mem_ref, o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata} !==
              {h_ref, !h_ref, h_addr, h_we, h_wdata}) begin
            failures++;
            $display("FAIL held_fields: got ref=%0b req=%0b addr=%0h we=%0b wd=%0h, expected ref=%0b req=%0b addr=%0h we=%0b wd=%0h",
                     o_mem_ref, o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, h_ref, !h_ref, h_addr, h_we, h_wdata);
          end
          if (!h_ref) begin
            if (h_we) sdram[h_addr] = h_wdata;
            else      i_mem_rdata = sdram_rd(h_addr);
          end
          i_mem_ack = 1'b1;
        end
      end
    end
  end

  // ---------------- grant monitor ----------------
  int gq[$];          // 1 = CPU, 2 = DMA, 3 = refresh, in issue order
  int ref_rise[$];
  int req_hi_cnt = 0, ref_hi_cnt = 0, dma_acks = 0;
  logic last_we;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  bit prev_req = 1'b0, prev_ref = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (o_mem_req && !prev_req) begin
        gq.push_back(o_mem_addr[AW-1] ? 2 : 1);
        last_we = o_mem_we; last_addr = o_mem_addr; last_wdata = o_mem_wdata;
      end
      if (o_mem_ref && !prev_ref) begin
        gq.push_back(3);
        ref_rise.push_back(cyc - rel_cyc);
      end
      if (o_mem_req) req_hi_cnt++;
      if (o_mem_ref) ref_hi_cnt++;
      if (o_dma_ack) dma_acks++;
      prev_req = o_mem_req;
      prev_ref = o_mem_ref;
    end
  end

  // ---------------- requester drivers ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    i_cpu_cs = 1'b0; i_dma_req = 1'b0; i_mem_ack = 1'b0;
    adp_busy = 1'b0; adp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic cpu_access(input bit rwb, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int waits);
    i_cpu_cs = 1'b1; i_cpu_rwb = rwb; i_cpu_addr = a; i_cpu_data = d;
    waits = 0;
    #1;
    while (o_cpu_wait && waits < BUDGET) begin
      waits++;
      @(negedge clk); #1;
    end
    checks++;
    if (o_cpu_wait) begin
      failures++;
      $display("FAIL cpu_timeout: got wait=%0b after %0d cycles, expected wait=0", o_cpu_wait, waits);
    end
  endtask

  task automatic dma_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd);
    int n = 0;
    i_dma_req = 1'b1; i_dma_we = we; i_dma_addr = a; i_dma_wdata = d;
    do begin
      @(negedge clk); #1; n++;
    end while (!o_dma_ack && n < BUDGET);
    checks++;
    if (!o_dma_ack) begin
      failures++;
      $display("FAIL dma_timeout: got ack=%0b after %0d cycles, expected ack=1", o_dma_ack, n);
    end
    rd = o_dma_rdata;
    i_dma_req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({o_cpu_data, o_cpu_wait, o_dma_ack, o_dma_rdata, o_mem_req, o_mem_we,
         o_mem_addr, o_mem_wdata, o_mem_ref} !== 54'd0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%0b ref=%0b addr=%0h cpu_data=%0h wait=%0b, expected all 0",
               o_mem_req, o_mem_ref, o_mem_addr, o_cpu_data, o_cpu_wait);
    end
  endtask

  task automatic test_cpu_read();
    int waits;
    apply_reset();
    sdram[25'h000123] = 8'h5A;
    adp_fixed = 3;
    @(negedge clk); #1;
    req_hi_cnt = 0;
    cpu_access(1'b1, 25'h000123, 8'h00, waits);
    checks++;
    if (waits !== 4) begin
      failures++; $display("FAIL read_wait_cycles: got %0d, expected 4", waits);
    end
    checks++;
    if (req_hi_cnt !== 3) begin
      failures++; $display("FAIL read_req_cycles: got %0d, expected 3", req_hi_cnt);
    end
    checks++;
    if ({last_we, last_addr} !== {1'b0, 25'h000123}) begin
      failures++; $display("FAIL read_fields: got we=%0b addr=%0h, expected we=0 addr=123", last_we, last_addr);
    end
    checks++;
    if (o_cpu_data !== 8'h5A) begin
      failures++; $display("FAIL read_data: got %0h, expected 5a", o_cpu_data);
    end
    i_cpu_cs = 1'b0;
  endtask

  task automatic test_cpu_write();
    int waits;
    apply_reset();
    sdram[25'h000022] = 8'h3C;
    adp_fixed = 3;
    @(negedge clk); #1;
    cpu_access(1'b1, 25'h000022, 8'h00, waits);
    cpu_access(1'b0, 25'h1F0000, 8'hA5, waits);
    checks++;
    if (waits !== 4) begin
      failures++; $display("FAIL write_wait_cycles: got %0d, expected 4", waits);
    end
    checks++;
    if ({last_we, last_addr, last_wdata} !== {1'b1, 25'h1F0000, 8'hA5}) begin
      failures++;
      $display("FAIL write_fields: got we=%0b addr=%0h wd=%0h, expected we=1 addr=1f0000 wd=a5",
               last_we, last_addr, last_wdata);
    end
    checks++;
    if (sdram_rd(25'h1F0000) !== 8'hA5) begin
      failures++; $display("FAIL write_stored: got %0h, expected a5", sdram_rd(25'h1F0000));
    end
    checks++;
    if (o_cpu_data !== 8'h3C) begin
      failures++; $display("FAIL write_keeps_cpu_data: got %0h, expected 3c", o_cpu_data);
    end
    i_cpu_cs = 1'b0;
  endtask

  task automatic test_burst_fairness();
    int exp_o[$];
    int got[$];
    int acks0;
    logic [DW-1:0] drd;
    apply_reset();
    adp_fixed = 0;
    for (int i = 0; i < 6; i++) sdram[AW'(32'h200 + i)] = DW'(i * 17 + 1);
    sdram[DMA_BASE + 25'd5] = 8'h77;
    @(negedge clk); #1;
    gq.delete();
    acks0 = dma_acks;
    fork
      begin
        int w;
        for (int i = 0; i < 6; i++) begin
          cpu_access(1'b1, AW'(32'h200 + i), 8'h00, w);
          checks++;
          if (o_cpu_data !== DW'(i * 17 + 1)) begin
            failures++;
            $display("FAIL burst_cpu_data[%0d]: got %0h, expected %0h", i, o_cpu_data, DW'(i * 17 + 1));
          end
        end
        i_cpu_cs = 1'b0;
      end
      dma_xfer(1'b0, DMA_BASE + 25'd5, 8'h00, drd);
    join
    repeat (3) @(negedge clk);
    exp_o = '{1, 1, 1, 1, 2, 1, 1};
    foreach (gq[i]) if (gq[i] != 3) got.push_back(gq[i]);
    checks++;
    if (got.size() !== exp_o.size()) begin
      failures++; $display("FAIL burst_grant_count: got %0d, expected %0d", got.size(), exp_o.size());
    end else begin
      foreach (exp_o[i]) begin
        checks++;
        if (got[i] !== exp_o[i]) begin
          failures++; $display("FAIL burst_grant_order[%0d]: got %0d, expected %0d", i, got[i], exp_o[i]);
        end
      end
    end
    checks++;
    if (dma_acks - acks0 !== 1) begin
      failures++; $display("FAIL burst_dma_ack_pulses: got %0d, expected 1", dma_acks - acks0);
    end
    checks++;
    if (drd !== 8'h77) begin
      failures++; $display("FAIL burst_dma_rdata: got %0h, expected 77", drd);
    end
  endtask

  task automatic test_refresh();
    logic [DW-1:0] drd;
    apply_reset();
    adp_fixed = 2;
    gq.delete();
    ref_rise.delete();
`ifdef SDRAM_ARB_REFRESH_EN
    // Counter wraps on the REF_IV-th edge after release; DMA arrives just after.
    while (cyc < rel_cyc + REF_IV) @(negedge clk);
    #1;
    dma_xfer(1'b0, DMA_BASE + 25'd9, 8'h00, drd);
    while (cyc < rel_cyc + 2 * REF_IV + 6) @(negedge clk);
    checks++;
    if (gq.size() < 3 || gq[0] !== 3 || gq[1] !== 2 || gq[2] !== 3) begin
      failures++;
      $display("FAIL refresh_order: got size=%0d first=%0d, expected sequence ref,dma,ref",
               gq.size(), (gq.size() > 0) ? gq[0] : -1);
    end
    checks++;
    if (ref_rise.size() !== 2) begin
      failures++; $display("FAIL refresh_count: got %0d, expected 2", ref_rise.size());
    end else begin
      checks++;
      if (ref_rise[0] !== REF_IV + 1 || ref_rise[1] !== 2 * REF_IV + 1) begin
        failures++;
        $display("FAIL refresh_timing: got %0d,%0d, expected %0d,%0d",
                 ref_rise[0], ref_rise[1], REF_IV + 1, 2 * REF_IV + 1);
      end
    end
`else
    ref_hi_cnt = 0;
    repeat (40) @(negedge clk);
    #1;
    dma_xfer(1'b0, DMA_BASE + 25'd9, 8'h00, drd);
    checks++;
    if (ref_hi_cnt !== 0) begin
      failures++; $display("FAIL no_refresh: got %0d ref cycles, expected 0", ref_hi_cnt);
    end
    checks++;
    if (gq.size() !== 1 || gq[0] !== 2) begin
      failures++; $display("FAIL dma_only_grant: got size=%0d, expected one DMA grant", gq.size());
    end
`endif
  endtask

  task automatic test_reset_mid_dma();
    int n = 0;
    int acks0;
    int waits;
    apply_reset();
    adp_en = 1'b0;
    @(negedge clk); #1;
    i_dma_req = 1'b1; i_dma_we = 1'b1; i_dma_addr = DMA_BASE + 25'd3; i_dma_wdata = 8'h4B;
    while (!o_mem_req && n < 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (o_mem_req !== 1'b1) begin
      failures++; $display("FAIL mid_reset_req_up: got %0b, expected 1", o_mem_req);
    end
    acks0 = dma_acks;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o_cpu_data, o_dma_ack, o_dma_rdata, o_mem_req, o_mem_we, o_mem_addr,
         o_mem_wdata, o_mem_ref} !== 53'd0) begin
      failures++;
      $display("FAIL mid_reset_async: got req=%0b we=%0b addr=%0h wd=%0h, expected all 0",
               o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata);
    end
    i_dma_req = 1'b0; adp_busy = 1'b0; i_mem_ack = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;
    adp_en = 1'b1;
    adp_fixed = 2;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (dma_acks - acks0 !== 0 || o_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_after: got acks=%0d req=%0b, expected acks=0 req=0", dma_acks - acks0, o_mem_req);
    end
    cpu_access(1'b1, 25'h000123, 8'h00, waits);
    checks++;
    if (waits !== 3) begin
      failures++; $display("FAIL mid_reset_idle_latency: got %0d, expected 3", waits);
    end
    i_cpu_cs = 1'b0;
  endtask

  task automatic test_spurious_ack();
    int waits, acks0, gsz;
    logic [DW-1:0] keep;
    apply_reset();
    adp_fixed = 2;
    sdram[25'h000050] = 8'hC3;
    @(negedge clk); #1;
    cpu_access(1'b1, 25'h000050, 8'h00, waits);
    i_cpu_cs = 1'b0;
    keep = o_cpu_data;
    repeat (2) @(negedge clk);
    acks0 = dma_acks;
    gsz = gq.size();
    adp_en = 1'b0;
    #1;
    i_mem_ack = 1'b1;
    i_mem_rdata = 8'hEE;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (o_cpu_data !== keep || o_cpu_data !== 8'hC3) begin
      failures++; $display("FAIL spurious_cpu_data: got %0h, expected c3", o_cpu_data);
    end
    checks++;
    if (dma_acks - acks0 !== 0 || gq.size() !== gsz || o_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL spurious_activity: got acks=%0d grants=%0d req=%0b, expected 0 0 0",
               dma_acks - acks0, gq.size() - gsz, o_mem_req);
    end
    adp_en = 1'b1;
    cpu_access(1'b1, 25'h000050, 8'h00, waits);
    checks++;
    if (waits !== 3) begin
      failures++; $display("FAIL spurious_then_latency: got %0d, expected 3", waits);
    end
    i_cpu_cs = 1'b0;
  endtask

  task automatic test_random_traffic();
    logic [DW-1:0] cpu_sh [logic [AW-1:0]];
    logic [DW-1:0] dma_sh [logic [AW-1:0]];
    apply_reset();
    adp_fixed = 0;
    @(negedge clk); #1;
    fork
      begin
        int w;
        for (int i = 0; i < 24; i++) begin
          bit rwb;
          logic [AW-1:0] a;
          logic [DW-1:0] d, e;
          rwb = 1'($urandom_range(0, 1));
          a = AW'(32'h400 + $urandom_range(0, 15));
          d = DW'($urandom);
          cpu_access(rwb, a, d, w);
          if (rwb) begin
            e = cpu_sh.exists(a) ? cpu_sh[a] : '0;
            checks++;
            if (o_cpu_data !== e) begin
              failures++; $display("FAIL rand_cpu_read @%0h: got %0h, expected %0h", a, o_cpu_data, e);
            end
          end else begin
            cpu_sh[a] = d;
          end
          i_cpu_cs = 1'b0;
          repeat ($urandom_range(1, 2)) @(negedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < 18; i++) begin
          bit we;
          logic [AW-1:0] a;
          logic [DW-1:0] d, e, rd;
          we = 1'($urandom_range(0, 1));
          a = DMA_BASE + AW'(32'h400 + $urandom_range(0, 15));
          d = DW'($urandom);
          dma_xfer(we, a, d, rd);
          if (!we) begin
            e = dma_sh.exists(a) ? dma_sh[a] : '0;
            checks++;
            if (rd !== e) begin
              failures++; $display("FAIL rand_dma_read @%0h: got %0h, expected %0h", a, rd, e);
            end
          end else begin
            dma_sh[a] = d;
          end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          #1;
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_burst_fairness();
    test_refresh();
    test_reset_mid_dma();
    test_spurious_ack();
    test_random_traffic();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion, expected finish within time limit");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM adapter port between three requesters: the CPU (through the mapped address/CS path), a DMA master, and an internal periodic refresh scheduler.
- Sits between the top-level address decode / SDRAM chip-select and the SDRAM adapter.
- Generates CPU wait (RDY) and a req/ack handshake for each side.

Parameters:
- ADDR_WIDTH, 25, mapped address width (matches mapper output).
- DATA_WIDTH, 8, data byte width.
- CPU_BURST_MAX, 4, consecutive CPU grants allowed while DMA is pending before DMA is forced in.
- REF_INTERVAL, 390, clk cycles between refresh requests (compiled only with refresh feature).

Ports:
- clk  in  1  CPU-domain clock; all logic in this domain.
- reset_n  in  1  asynchronous active-low reset.
- i_cpu_cs  in  1  SDRAM chip-select from decode (level).
- i_cpu_rwb  in  1  1=read, 0=write.
- i_cpu_addr  in  ADDR_WIDTH  mapped CPU address.
- i_cpu_data  in  DATA_WIDTH  CPU write data.
- o_cpu_data  out  DATA_WIDTH  registered CPU read data.
- o_cpu_wait  out  1  stall CPU (drives RDY low).
- i_dma_req  in  1  DMA request (level).
- i_dma_we  in  1  DMA write enable.
- i_dma_addr  in  ADDR_WIDTH  DMA address.
- i_dma_wdata  in  DATA_WIDTH  DMA write data.
- o_dma_ack  out  1  one-cycle completion pulse.
- o_dma_rdata  out  DATA_WIDTH  DMA read data, valid with o_dma_ack.
- o_mem_req  out  1  access request to adapter.
- o_mem_we  out  1  write enable.
- o_mem_addr  out  ADDR_WIDTH  access address.
- o_mem_wdata  out  DATA_WIDTH  write data.
- o_mem_ref  out  1  refresh request to adapter.
- i_mem_ack  in  1  one-cycle completion pulse from adapter.
- i_mem_rdata  in  DATA_WIDTH  read data, valid with i_mem_ack.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; cpu_done 0.
- States: IDLE, CPU_ACC, DMA_ACC, REF.
- Priority evaluated in IDLE each cycle:
  - ref_pending first.
  - Then DMA, if i_dma_req and cpu_streak >= CPU_BURST_MAX.
  - Then CPU, if i_cpu_cs and !cpu_done.
  - Then DMA, if i_dma_req.
- Grant transition (cycle t):
  - Address, we and wdata are registered into o_mem_* and o_mem_req (or o_mem_ref) is set at t+1.
  - These are held stable until i_mem_ack.
- On i_mem_ack in CPU_ACC:
  - o_cpu_data <= i_mem_rdata (reads only; writes leave it unchanged).
  - cpu_done <= 1; o_mem_req <= 0; return to IDLE.
- On i_mem_ack in DMA_ACC:
  - o_dma_ack pulses 1 cycle next edge and o_dma_rdata registered; o_mem_req <= 0; return to IDLE.
- On i_mem_ack in REF: o_mem_ref <= 0; ref_pending cleared; return to IDLE.
- i_mem_ack in IDLE is ignored.
- o_cpu_wait = i_cpu_cs & ~cpu_done (combinational). It therefore deasserts on the cycle after ack.
- cpu_done clears when i_cpu_cs is low, or i_cpu_addr/i_cpu_rwb differ from the latched values. Back-to-back accesses to different addresses re-arbitrate.
- cpu_streak:
  - Increments (saturating at CPU_BURST_MAX) on each CPU grant while i_dma_req is high.
  - Clears on a DMA grant, or when i_dma_req is low.
- Minimum CPU latency: cs at cycle 0, o_mem_req at 1, earliest ack at 2, wait low at 3.
- DMA fields must be stable from req until o_dma_ack. DMA may hold req for consecutive transfers.
- Simultaneous CPU, DMA and refresh: refresh wins. CPU and DMA then follow the streak rule.
- Reset mid-transaction: immediate return to IDLE with o_mem_req and o_mem_ref dropped. The adapter shares the same reset.

Optional Feature:
- SDRAM_ARB_REFRESH_EN defined:
  - Counter runs 0..REF_INTERVAL-1. Wrap sets ref_pending (does not stack; a second wrap while pending is lost).
  - Refresh preempts the next IDLE arbitration only, never an in-flight access.
- Undefined: no counter, ref_pending tied 0, o_mem_ref constant 0, REF state unreachable. The adapter then handles refresh itself.

Decomposition:
- Package sdram_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, CPU_ACC, DMA_ACC, REF}.
  - typedef enum grant_t {GNT_NONE, GNT_CPU, GNT_DMA, GNT_REF}.
  - Default width constants.
- One sub-module, refresh_timer (counter plus pending flag), instantiated only under SDRAM_ARB_REFRESH_EN.

Test Plan:
- CPU read, addr 0x000123; adapter acks 3 cycles after req with rdata 0x5A:
  - o_mem_req high for 3 cycles, o_mem_we=0.
  - o_cpu_wait high until the cycle after ack; o_cpu_data=0x5A.
- CPU write 0xA5 to 0x1F0000:
  - o_mem_we=1, o_mem_wdata=0xA5 held until ack; o_cpu_data unchanged.
- CPU_BURST_MAX=4, DMA req held while CPU issues 6 accesses to distinct addresses: grant order CPU×4, DMA, CPU×2; o_dma_ack exactly one pulse.
- Refresh enabled, REF_INTERVAL=16, DMA req pending at the wrap cycle: o_mem_ref is issued before DMA; ref_pending clears on ack.
- reset_n low during DMA_ACC with o_mem_req=1: all outputs 0 asynchronously; after release, state IDLE and no o_dma_ack.
- Spurious i_mem_ack in IDLE: no state change, no ack pulses, o_cpu_data unchanged.
